// File: rtl/rc4_pkg.sv
// Shared types and defaults for the RC4 key-scheduling engine.
// The INIT state is only reachable when RC4_KSA_INIT_EN is defined.
package rc4_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    INIT  = 4'd1,
    RD_I  = 4'd2,
    CAP_I = 4'd3,
    RD_J  = 4'd4,
    CAP_J = 4'd5,
    WR_I  = 4'd6,
    WR_J  = 4'd7,
    DONE  = 4'd8
  } ksa_state_t;

  localparam int DEF_KEY_BYTES = 3;
  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_RD_LAT    = 1;

  // Clock cycles spent on one KSA iteration (two reads, two captures, two writes).
  function automatic int ksa_iter_cycles(input int rd_lat);
    return 2 * rd_lat + 4;
  endfunction

  localparam int DEF_ITER_CYCLES = 2 * DEF_RD_LAT + 4;

endpackage

// File: rtl/rc4_key_byte_sel.sv
// Key byte selector: returns byte kidx of the secret key, byte 0 being the
// most significant byte. Shared with the PRGA stage so the ordering lives here.
module rc4_key_byte_sel #(
  parameter int KEY_BYTES = 3,
  parameter int KIDX_W    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1
) (
  input  logic [8*KEY_BYTES-1:0] i_key,
  input  logic [KIDX_W-1:0]      i_kidx,
  output logic [7:0]             o_byte
);

  // One-hot style mux over the key bytes, MSB-first.
  always_comb begin
    o_byte = 8'h00;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (i_kidx == KIDX_W'(k)) begin
        o_byte = i_key[8*(KEY_BYTES-1-k) +: 8];
      end
    end
  end

endmodule

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine driving a single-port S-box RAM.
// Each iteration reads s[i] and s[j], updates j and writes the pair back
// swapped. Optional macro RC4_KSA_INIT_EN adds an INIT state that first
// loads the identity permutation into the RAM.
module rc4_ksa_engine
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = DEF_KEY_BYTES,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int RD_LAT    = DEF_RD_LAT
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [7:0]             q,
  output logic                   finish,
  output logic                   wren,
  output logic [ADDR_W-1:0]      address,
  output logic [7:0]             data
);

  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  ksa_state_t        r_state;
  ksa_state_t        w_next;
  logic [ADDR_W-1:0] r_i;
  logic [ADDR_W-1:0] r_j;
  logic [KIDX_W-1:0] r_kidx;
  logic [1:0]        r_wait;
  logic [7:0]        r_si;
  logic [7:0]        r_sj;

  logic [7:0]        w_key_byte;
  logic              w_wait_done;
  logic              w_last_i;
  logic              w_last_kidx;

  assign w_wait_done = (r_wait == 2'(RD_LAT - 1));
  assign w_last_i    = (r_i == {ADDR_W{1'b1}});
  assign w_last_kidx = (r_kidx == KIDX_W'(KEY_BYTES - 1));

  rc4_key_byte_sel #(
    .KEY_BYTES (KEY_BYTES),
    .KIDX_W    (KIDX_W)
  ) u_key_sel (
    .i_key  (secret_key),
    .i_kidx (r_kidx),
    .o_byte (w_key_byte)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
`ifdef RC4_KSA_INIT_EN
          w_next = INIT;
`else
          w_next = RD_I;
`endif
        end
      end
`ifdef RC4_KSA_INIT_EN
      INIT:    if (w_last_i) w_next = RD_I;
`endif
      RD_I:    if (w_wait_done) w_next = CAP_I;
      CAP_I:   w_next = RD_J;
      RD_J:    if (w_wait_done) w_next = CAP_J;
      CAP_J:   w_next = WR_I;
      WR_I:    w_next = WR_J;
      WR_J:    w_next = w_last_i ? DONE : RD_I;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // RAM-side outputs decoded from state and registered counters; the address
  // is held through the capture cycle so longer read pipelines see it stable.
  always_comb begin
    wren    = 1'b0;
    address = '0;
    data    = 8'h00;
    finish  = 1'b0;
    case (r_state)
`ifdef RC4_KSA_INIT_EN
      INIT: begin
        wren    = 1'b1;
        address = r_i;
        data    = 8'(r_i);
      end
`endif
      RD_I, CAP_I: address = r_i;
      RD_J, CAP_J: address = r_j;
      WR_I: begin
        wren    = 1'b1;
        address = r_i;
        data    = r_sj;
      end
      WR_J: begin
        wren    = 1'b1;
        address = r_j;
        data    = r_si;
      end
      DONE:    finish = 1'b1;
      default: ;
    endcase
  end

  // Counters, read-wait timer and captured S-box values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_i    <= '0;
      r_j    <= '0;
      r_kidx <= '0;
      r_wait <= 2'd0;
      // NOTE: the captured bytes are ordinary flops, so they are reset to keep
      // data at 0 out of reset; the S-box itself lives in the external RAM.
      r_si   <= 8'h00;
      r_sj   <= 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_i    <= '0;
            r_j    <= '0;
            r_kidx <= '0;
            r_wait <= 2'd0;
          end
        end
`ifdef RC4_KSA_INIT_EN
        INIT: r_i <= r_i + 1'b1;
`endif
        RD_I, RD_J: r_wait <= w_wait_done ? 2'd0 : r_wait + 2'd1;
        CAP_I: begin
          r_si <= q;
          r_j  <= r_j + ADDR_W'(q) + ADDR_W'(w_key_byte);
        end
        CAP_J: r_sj <= q;
        WR_J: begin
          r_i    <= r_i + 1'b1;
          r_kidx <= w_last_kidx ? '0 : r_kidx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Self-checking bench for rc4_ksa_engine: behavioural RAMs, a plain-array
// KSA reference model producing the expected write trace and final S-box,
// and a per-cycle compare process for each of two parameterisations.
module tb_rc4_ksa_engine;

`ifdef RC4_KSA_INIT_EN
  localparam bit INIT = 1'b1;
`else
  localparam bit INIT = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // DUT A: defaults (KEY_BYTES=3, ADDR_W=8, RD_LAT=1)
  logic        start_a = 1'b0;
  logic [23:0] key_a = '0;
  logic [7:0]  q_a;
  logic        finish_a, wren_a;
  logic [7:0]  address_a, data_a;

  // DUT B: KEY_BYTES=4, ADDR_W=4, RD_LAT=2
  logic        start_b = 1'b0;
  logic [31:0] key_b = '0;
  logic [7:0]  q_b;
  logic        finish_b, wren_b;
  logic [3:0]  address_b;
  logic [7:0]  data_b;

  rc4_ksa_engine u_dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a), .secret_key(key_a),
    .q(q_a), .finish(finish_a), .wren(wren_a), .address(address_a), .data(data_a)
  );

  rc4_ksa_engine #(.KEY_BYTES(4), .ADDR_W(4), .RD_LAT(2)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b), .secret_key(key_b),
    .q(q_b), .finish(finish_b), .wren(wren_b), .address(address_b), .data(data_b)
  );

  // Behavioural RAMs with 1- and 2-cycle read latency.
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [16];
  logic [7:0] pa = '0;
  logic [3:0] pb0 = '0, pb1 = '0;
  bit preset_a = 1'b0, preset_b = 1'b0, preset_ff = 1'b0;

  always @(posedge clock) begin
    if (preset_a) for (int k = 0; k < 256; k++) mem_a[k] <= preset_ff ? 8'hFF : 8'(k);
    else if (wren_a) mem_a[address_a] <= data_a;
    pa <= address_a;
  end
  assign q_a = mem_a[pa];

  always @(posedge clock) begin
    if (preset_b) for (int k = 0; k < 16; k++) mem_b[k] <= preset_ff ? 8'hFF : 8'(k);
    else if (wren_b) mem_b[address_b] <= data_b;
    pb0 <= address_b;
    pb1 <= pb0;
  end
  assign q_b = mem_b[pb1];

  wr_t        exp_a[$];
  wr_t        exp_b[$];
  wr_t        wlog[$];
  logic [7:0] gold [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference KSA on a plain array; records every expected RAM write in order.
  task automatic build_model(input int dut, input logic [255:0] key);
    int n, kb, j;
    logic [7:0] s [256];
    logic [7:0] t, kbyte;
    wr_t w;
    n  = dut ? 16 : 256;
    kb = dut ? 4 : 3;
    if (dut == 0) exp_a.delete(); else exp_b.delete();
    for (int k = 0; k < n; k++) begin
      s[k] = 8'(k);
      if (INIT) begin
        w = {8'(k), 8'(k)};
        if (dut == 0) exp_a.push_back(w); else exp_b.push_back(w);
      end
    end
    j = 0;
    for (int i = 0; i < n; i++) begin
      kbyte = key[8*(kb-1-(i%kb)) +: 8];
      j = (j + int'(s[i]) + int'(kbyte)) % n;
      w = {8'(i), s[j]};
      if (dut == 0) exp_a.push_back(w); else exp_b.push_back(w);
      w = {8'(j), s[i]};
      if (dut == 0) exp_a.push_back(w); else exp_b.push_back(w);
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    for (int k = 0; k < 256; k++) gold[k] = (k < n) ? s[k] : 8'h00;
  endtask

  // Per-cycle write-trace comparison for DUT A.
  always @(negedge clock) begin : cmp_a
    wr_t e;
    if (reset_n && wren_a) begin
      wlog.push_back({address_a, data_a});
      if (exp_a.size() == 0) check("A extra write", 32'(exp_a.size()), 32'd1);
      else begin
        e = exp_a.pop_front();
        check("A wr addr", {24'd0, address_a}, {24'd0, e.a});
        check("A wr data", {24'd0, data_a}, {24'd0, e.d});
      end
    end
  end

  // Per-cycle write-trace comparison for DUT B.
  always @(negedge clock) begin : cmp_b
    wr_t e;
    if (reset_n && wren_b) begin
      if (exp_b.size() == 0) check("B extra write", 32'(exp_b.size()), 32'd1);
      else begin
        e = exp_b.pop_front();
        check("B wr addr", {28'd0, address_b}, {24'd0, e.a});
        check("B wr data", {24'd0, data_b}, {24'd0, e.d});
      end
    end
  end

  function automatic logic [31:0] outs(input int dut);
    if (dut == 0) return {14'd0, finish_a, wren_a, address_a, data_a};
    return {18'd0, finish_b, wren_b, address_b, data_b};
  endfunction

  // mode 0: plain run; 1: extra start pulses mid-run; 2: async reset at cycle 100.
  task automatic run(input int dut, input logic [255:0] key, input int mode);
    int n, nn, lat_exp, bad, extra;
    bit got;
    logic [7:0] m;
    nn      = dut ? 16 : 256;
    lat_exp = dut ? (INIT ? 144 : 128) : (INIT ? 1792 : 1536);
    if (dut == 0) key_a = key[23:0]; else key_b = key[31:0];
    @(negedge clock);
    if (dut == 0) preset_a = 1'b1; else preset_b = 1'b1;
    @(negedge clock);
    preset_a = 1'b0; preset_b = 1'b0;
    build_model(dut, key);
    wlog.delete();
    if (dut == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clock);
    #1;
    start_a = 1'b0; start_b = 1'b0;
    n = 0; got = 1'b0;
    while (n < 4000 && !got) begin
      @(posedge clock);
      n++;
      #1;
      if (mode == 1) begin
        if (dut == 0) start_a = (n == 50 || n == 51); else start_b = (n == 50 || n == 51);
      end
      if (mode == 2 && n == 100) begin
        #2 reset_n = 1'b0;
        #1 check("async reset outputs", outs(dut), 32'd0);
        exp_a.delete(); exp_b.delete();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        return;
      end
      if ((dut == 0) ? finish_a : finish_b) got = 1'b1;
    end
    start_a = 1'b0; start_b = 1'b0;
    if (!got) begin
      check("finish timeout", 32'(n), 32'(lat_exp));
      return;
    end
    check("finish latency", 32'(n), 32'(lat_exp));
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock);
      #1;
      if ((dut == 0) ? finish_a : finish_b) extra++;
    end
    check("single finish pulse", 32'(extra), 32'd0);
    check("write trace drained", 32'(dut ? exp_b.size() : exp_a.size()), 32'd0);
    bad = 0;
    for (int k = 0; k < nn; k++) begin
      m = dut ? mem_b[k] : mem_a[k];
      if (m !== gold[k]) bad++;
    end
    check("RAM vs model", 32'(bad), 32'd0);
  endtask

  task automatic check_log(input string name, input int idx, input logic [15:0] exp);
    if (idx < wlog.size()) check(name, {16'd0, wlog[idx]}, {16'd0, exp});
    else check({name, " missing"}, 32'(wlog.size()), 32'(idx + 1));
  endtask

  initial begin
    int base;
    base = INIT ? 256 : 0;
    preset_ff = INIT;
    #3;
    check("reset outs A", outs(0), 32'd0);
    check("reset outs B", outs(1), 32'd0);
    #20;
    @(negedge clock);
    reset_n = 1'b1;

    run(0, 256'h000000, 0);
    check_log("key0 iter0 WR_I", base + 0, 16'h0000);
    check_log("key0 iter0 WR_J", base + 1, 16'h0000);
    if (INIT) begin
      check_log("init k=0", 0, 16'h0000);
      check_log("init k=1", 1, 16'h0101);
      check_log("init k=255", 255, 16'hFFFF);
    end

    run(0, 256'h0A0B0C, 0);
    check_log("key0A iter0 WR_I", base + 0, 16'h000A);
    check_log("key0A iter0 WR_J", base + 1, 16'h0A00);
    check_log("key0A iter1 WR_I", base + 2, 16'h0116);
    check_log("key0A iter1 WR_J", base + 3, 16'h1601);

    run(0, 256'($urandom_range(24'hFFFFFF, 0)), 1);
    run(0, 256'($urandom_range(24'hFFFFFF, 0)), 2);
    run(0, 256'($urandom_range(24'hFFFFFF, 0)), 0);

    run(1, 256'h01020304, 0);
    run(1, 256'($urandom), 0);
    run(1, 256'($urandom), 0);
    run(0, 256'($urandom_range(24'hFFFFFF, 0)), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
